// File: rtl/vending_machine_core_pkg.sv
// Shared definitions for the vending machine core.
// Contents: FSM state type plus the default sizing, coin values and item
// prices used by the core, its interface and the change selector.
package vending_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        RETURN = 2'd2
    } vm_state_e;

    localparam int DEF_NUM_COINS   = 3;
    localparam int DEF_NUM_ITEMS   = 4;
    localparam int DEF_TOTAL_BITS  = 31;
    localparam int DEF_WAIT_CYCLES = 100;
    localparam int DEF_MAX_TOTAL   = 1000000;

    // Index 0 is the lowest value in both arrays.
    localparam logic [DEF_NUM_COINS-1:0][31:0] DEF_COIN_VALUES =
        {32'd1000, 32'd500, 32'd100};
    localparam logic [DEF_NUM_ITEMS-1:0][31:0] DEF_ITEM_PRICES =
        {32'd2000, 32'd1000, 32'd500, 32'd400};

endpackage

// File: rtl/vending_machine_core_if.sv
// Front-end / actuator bundle of the vending machine core.
// master: coin/button front end (drives coin, select and return strobes,
//         observes credit, availability, dispense pulses and busy).
// slave : vending_machine_core.
interface vending_machine_core_if
    import vending_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int NUM_ITEMS  = DEF_NUM_ITEMS,
    parameter int TOTAL_BITS = DEF_TOTAL_BITS
);

    logic [NUM_COINS-1:0]  i_input_coin;
    logic [NUM_ITEMS-1:0]  i_select_item;
    logic                  i_trigger_return;
    logic [NUM_ITEMS-1:0]  o_available_item;
    logic [NUM_ITEMS-1:0]  o_output_item;
    logic [NUM_COINS-1:0]  o_return_coin;
    logic                  o_coin_rejected;
    logic                  o_busy;
    logic [TOTAL_BITS-1:0] o_current_total;

    modport master (
        output i_input_coin,
        output i_select_item,
        output i_trigger_return,
        input  o_available_item,
        input  o_output_item,
        input  o_return_coin,
        input  o_coin_rejected,
        input  o_busy,
        input  o_current_total
    );

    modport slave (
        input  i_input_coin,
        input  i_select_item,
        input  i_trigger_return,
        output o_available_item,
        output o_output_item,
        output o_return_coin,
        output o_coin_rejected,
        output o_busy,
        output o_current_total
    );

endinterface

// File: rtl/vending_machine_core_change_selector.sv
// Greedy change finder: picks the largest coin whose value fits in credit.
// Ports:
//   credit      in  credit to pay out
//   coin_onehot out one-hot index of the chosen coin (0 when none fits)
//   coin_value  out value of the chosen coin (0 when none fits)
//   found       out a coin fits
module vm_change_selector
    import vending_pkg::*;
#(
    parameter int NUM_COINS  = DEF_NUM_COINS,
    parameter int VALUE_BITS = DEF_TOTAL_BITS + 1,
    parameter logic [NUM_COINS-1:0][31:0] COIN_VALUES = DEF_COIN_VALUES
) (
    input  logic [VALUE_BITS-1:0] credit,
    output logic [NUM_COINS-1:0]  coin_onehot,
    output logic [VALUE_BITS-1:0] coin_value,
    output logic                  found
);

    // Coin values ascend with index, so the last fitting coin is the largest.
    always_comb begin
        coin_onehot = '0;
        coin_value  = '0;
        found       = 1'b0;
        for (int j = 0; j < NUM_COINS; j++) begin
            if (64'(COIN_VALUES[j]) <= 64'(credit)) begin
                coin_onehot    = '0;
                coin_onehot[j] = 1'b1;
                coin_value     = VALUE_BITS'(COIN_VALUES[j]);
                found          = 1'b1;
            end
        end
    end

endmodule

// File: rtl/vending_machine_core.sv
// Vending machine core: running credit, purchase resolution, idle timeout
// and one-coin-per-cycle change dispensing.
// Ports:
//   clk   in  clock
//   reset in  synchronous reset, active-high
//   bus   slave side of vending_machine_core_if (coin/select/return strobes
//         in; availability, dispense pulses, reject, busy and credit out)
//
// state  | meaning
// -------+-------------------------------------------------------------
// IDLE   | credit is 0; waits for an accepted coin
// ACTIVE | credit > 0; purchases resolved, idle timer running
// RETURN | paying out change, one coin per cycle; inputs ignored
module vending_machine_core
    import vending_pkg::*;
#(
    parameter int NUM_COINS   = DEF_NUM_COINS,
    parameter int NUM_ITEMS   = DEF_NUM_ITEMS,
    parameter int TOTAL_BITS  = DEF_TOTAL_BITS,
    parameter logic [NUM_COINS-1:0][31:0] COIN_VALUES = DEF_COIN_VALUES,
    parameter logic [NUM_ITEMS-1:0][31:0] ITEM_PRICES = DEF_ITEM_PRICES,
    parameter int WAIT_CYCLES = DEF_WAIT_CYCLES,
    parameter int MAX_TOTAL   = DEF_MAX_TOTAL
) (
    input logic clk,
    input logic reset,
    vending_machine_core_if.slave bus
);

    // One spare bit so coin add and purchase arithmetic never wraps.
    localparam int W         = TOTAL_BITS + 1;
    localparam int WAIT_BITS = $clog2(WAIT_CYCLES + 1);

    typedef logic [W-1:0] acc_t;

    localparam acc_t                 MAX_ACC   = acc_t'(MAX_TOTAL);
    localparam acc_t                 COIN_MIN  = acc_t'(COIN_VALUES[0]);
    localparam logic [WAIT_BITS-1:0] WAIT_LOAD = WAIT_BITS'(WAIT_CYCLES);

    vm_state_e             state_q, state_d;
    logic [TOTAL_BITS-1:0] total_q, total_d;
    logic [WAIT_BITS-1:0]  wait_q, wait_d;
    logic [NUM_ITEMS-1:0]  item_q, item_d;
    logic [NUM_COINS-1:0]  coin_q, coin_d;
    logic                  rej_q, rej_d;

    acc_t                 credit_now;
    acc_t                 in_sum;
    acc_t                 run;
    acc_t                 residual;
    acc_t                 change_value;
    logic [NUM_COINS-1:0] change_onehot;
    logic                 change_found;
    logic                 coin_any;
    logic                 over_cap;
    logic                 coin_ok;
    logic                 reload;
    logic [NUM_ITEMS-1:0] avail;

    assign credit_now = {1'b0, total_q};
    assign coin_any   = |bus.i_input_coin;
    assign over_cap   = (credit_now + in_sum) > MAX_ACC;
    assign coin_ok    = coin_any && !over_cap;
    assign residual   = credit_now - change_value;

    always_comb begin
        in_sum = '0;
        for (int i = 0; i < NUM_COINS; i++) begin
            if (bus.i_input_coin[i]) begin
                in_sum = in_sum + acc_t'(COIN_VALUES[i]);
            end
        end
    end

    vm_change_selector #(
        .NUM_COINS  (NUM_COINS),
        .VALUE_BITS (W),
        .COIN_VALUES(COIN_VALUES)
    ) u_change_selector (
        .credit     (credit_now),
        .coin_onehot(change_onehot),
        .coin_value (change_value),
        .found      (change_found)
    );

    always_comb begin
        state_d = state_q;
        total_d = total_q;
        wait_d  = wait_q;
        item_d  = '0;
        coin_d  = '0;
        rej_d   = 1'b0;
        run     = credit_now;
        reload  = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (coin_any) begin
                    if (over_cap) begin
                        rej_d = 1'b1;
                    end else begin
                        total_d = TOTAL_BITS'(credit_now + in_sum);
                        wait_d  = WAIT_LOAD;
                        state_d = ACTIVE;
                    end
                end
            end

            ACTIVE: begin
                if (coin_any) begin
                    if (over_cap) begin
                        rej_d = 1'b1;
                    end else begin
                        run = run + in_sum;
                    end
                end
                // Lower index wins when credit cannot cover every selection.
                for (int i = 0; i < NUM_ITEMS; i++) begin
                    if (bus.i_select_item[i] && (run >= acc_t'(ITEM_PRICES[i]))) begin
                        run       = run - acc_t'(ITEM_PRICES[i]);
                        item_d[i] = 1'b1;
                    end
                end
                total_d = run[TOTAL_BITS-1:0];
                reload  = coin_ok || (item_d != '0);

                if (run == '0) begin
                    // Nothing left to refund, so a return request is moot.
                    wait_d  = WAIT_LOAD;
                    state_d = IDLE;
                end else begin
                    if (reload) begin
                        wait_d = WAIT_LOAD;
                    end else begin
                        wait_d = wait_q - 1'b1;
                    end
                    if (bus.i_trigger_return ||
                        (!reload && (wait_q <= WAIT_BITS'(1)))) begin
                        state_d = RETURN;
                    end
                end
            end

            RETURN: begin
                if (change_found) begin
                    coin_d  = change_onehot;
                    total_d = residual[TOTAL_BITS-1:0];
                end
                // Leave as soon as no further coin would fit; any residual
                // below the smallest coin is forfeited.
                if (!change_found || (residual < COIN_MIN)) begin
                    total_d = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                total_d = '0;
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            total_q <= '0;
            wait_q  <= WAIT_LOAD;
            item_q  <= '0;
            coin_q  <= '0;
            rej_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            total_q <= total_d;
            wait_q  <= wait_d;
            item_q  <= item_d;
            coin_q  <= coin_d;
            rej_q   <= rej_d;
        end
    end

    always_comb begin
        avail = '0;
        for (int i = 0; i < NUM_ITEMS; i++) begin
            avail[i] = credit_now >= acc_t'(ITEM_PRICES[i]);
        end
    end

    assign bus.o_available_item = avail;
    assign bus.o_output_item    = item_q;
    assign bus.o_return_coin    = coin_q;
    assign bus.o_coin_rejected  = rej_q;
    assign bus.o_busy           = (state_q == RETURN);
    assign bus.o_current_total  = total_q;

endmodule

// File: tb/tb_vending_machine_core.sv
module tb_vending_machine_core;

    localparam int NC = 3;
    localparam int NI = 4;
    localparam int TB = 31;
    localparam int B_WAIT = 8;
    localparam int B_MAX  = 2000;
    localparam int N_RAND = 3000;

    logic clk = 1'b0;
    logic reset_a;
    logic reset_b;

    always #5 clk = ~clk;

    vending_machine_core_if #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TB)) bus_a ();
    vending_machine_core_if #(.NUM_COINS(NC), .NUM_ITEMS(NI), .TOTAL_BITS(TB)) bus_b ();

    vending_machine_core #(
        .NUM_COINS  (NC),
        .NUM_ITEMS  (NI),
        .TOTAL_BITS (TB),
        .WAIT_CYCLES(100),
        .MAX_TOTAL  (1000000)
    ) dut_a (
        .clk  (clk),
        .reset(reset_a),
        .bus  (bus_a.slave)
    );

    vending_machine_core #(
        .NUM_COINS  (NC),
        .NUM_ITEMS  (NI),
        .TOTAL_BITS (TB),
        .WAIT_CYCLES(B_WAIT),
        .MAX_TOTAL  (B_MAX)
    ) dut_b (
        .clk  (clk),
        .reset(reset_b),
        .bus  (bus_b.slave)
    );

    int COIN_V [NC] = '{100, 500, 1000};
    int PRICE_V[NI] = '{400, 500, 1000, 2000};

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic [2:0] coin;
        logic [3:0] sel;
        logic       trig;
        int         total;
        logic [3:0] item;
        logic [2:0] ret;
        logic       rej;
        logic       busy;
        logic [3:0] avail;
    } vec_t;

    vec_t vecs[19];

    // Reference model for dut_b: credit, a timeout countdown and a queue of
    // change coins fixed when the payout starts.
    int         m_credit;
    bit         m_ret;
    int         m_timer;
    int         m_q[$];
    logic [3:0] e_item;
    logic [2:0] e_coin;
    logic       e_rej;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_a(input string tag, input int total, input logic [3:0] item,
                           input logic [2:0] ret, input logic rej, input logic busy,
                           input logic [3:0] avail);
        check({tag, " total"}, 64'(bus_a.o_current_total), 64'(total));
        check({tag, " item"},  64'(bus_a.o_output_item),   64'(item));
        check({tag, " coin"},  64'(bus_a.o_return_coin),   64'(ret));
        check({tag, " rej"},   64'(bus_a.o_coin_rejected), 64'(rej));
        check({tag, " busy"},  64'(bus_a.o_busy),          64'(busy));
        check({tag, " avail"}, 64'(bus_a.o_available_item), 64'(avail));
    endtask

    task automatic check_b(input string tag, input int total, input logic [3:0] item,
                           input logic [2:0] ret, input logic rej, input logic busy,
                           input logic [3:0] avail);
        check({tag, " total"}, 64'(bus_b.o_current_total), 64'(total));
        check({tag, " item"},  64'(bus_b.o_output_item),   64'(item));
        check({tag, " coin"},  64'(bus_b.o_return_coin),   64'(ret));
        check({tag, " rej"},   64'(bus_b.o_coin_rejected), 64'(rej));
        check({tag, " busy"},  64'(bus_b.o_busy),          64'(busy));
        check({tag, " avail"}, 64'(bus_b.o_available_item), 64'(avail));
    endtask

    task automatic drive_a(input logic [2:0] c, input logic [3:0] s, input logic t);
        bus_a.i_input_coin     = c;
        bus_a.i_select_item    = s;
        bus_a.i_trigger_return = t;
    endtask

    task automatic drive_b(input logic [2:0] c, input logic [3:0] s, input logic t);
        bus_b.i_input_coin     = c;
        bus_b.i_select_item    = s;
        bus_b.i_trigger_return = t;
    endtask

    function automatic logic [3:0] affordable(input int credit);
        logic [3:0] a;
        for (int i = 0; i < NI; i++) a[i] = (credit >= PRICE_V[i]);
        return a;
    endfunction

    task automatic model_step(input bit rst, input logic [2:0] c, input logic [3:0] s, input bit t);
        int  sum;
        bit  idle;
        bit  acc;
        bit  bought;
        int  rem;
        e_item = '0;
        e_coin = '0;
        e_rej  = 1'b0;
        if (rst) begin
            m_credit = 0;
            m_ret    = 0;
            m_timer  = B_WAIT;
            m_q.delete();
            return;
        end
        if (m_ret) begin
            if (m_q.size() > 0) begin
                int j;
                j = m_q.pop_front();
                e_coin[j] = 1'b1;
                m_credit -= COIN_V[j];
            end
            if (m_q.size() == 0) begin
                m_credit = 0;
                m_ret    = 0;
            end
            return;
        end
        sum = 0;
        for (int i = 0; i < NC; i++) if (c[i]) sum += COIN_V[i];
        idle = (m_credit == 0);
        acc  = (sum > 0) && (m_credit + sum <= B_MAX);
        if (sum > 0 && !acc) e_rej = 1'b1;
        if (acc) m_credit += sum;
        if (idle) begin
            if (acc) m_timer = B_WAIT;
            return;
        end
        bought = 0;
        for (int i = 0; i < NI; i++) begin
            if (s[i] && m_credit >= PRICE_V[i]) begin
                m_credit -= PRICE_V[i];
                e_item[i] = 1'b1;
                bought = 1;
            end
        end
        if (m_credit == 0) return;
        if (acc || bought) m_timer = B_WAIT;
        else m_timer--;
        if (t || m_timer == 0) begin
            m_ret = 1;
            rem = m_credit;
            while (rem >= COIN_V[0]) begin
                for (int j = NC - 1; j >= 0; j--) begin
                    if (COIN_V[j] <= rem) begin
                        m_q.push_back(j);
                        rem -= COIN_V[j];
                        break;
                    end
                end
            end
        end
    endtask

    initial begin
        //            coin    sel      trig  total item     ret     rej   busy  avail
        vecs[0]  = '{3'b010, 4'b0000, 1'b0, 500,  4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011};
        vecs[1]  = '{3'b001, 4'b0000, 1'b0, 600,  4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011};
        vecs[2]  = '{3'b001, 4'b0000, 1'b0, 700,  4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011};
        vecs[3]  = '{3'b001, 4'b0000, 1'b0, 800,  4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011};
        vecs[4]  = '{3'b001, 4'b0000, 1'b0, 900,  4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011};
        vecs[5]  = '{3'b001, 4'b0000, 1'b0, 1000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111};
        vecs[6]  = '{3'b000, 4'b0011, 1'b0, 100,  4'b0011, 3'b000, 1'b0, 1'b0, 4'b0000};
        vecs[7]  = '{3'b010, 4'b0010, 1'b0, 100,  4'b0010, 3'b000, 1'b0, 1'b0, 4'b0000};
        vecs[8]  = '{3'b100, 4'b0000, 1'b0, 1100, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111};
        vecs[9]  = '{3'b010, 4'b0000, 1'b0, 1600, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111};
        vecs[10] = '{3'b000, 4'b0000, 1'b1, 1600, 4'b0000, 3'b000, 1'b0, 1'b1, 4'b0111};
        vecs[11] = '{3'b000, 4'b0000, 1'b0, 600,  4'b0000, 3'b100, 1'b0, 1'b1, 4'b0011};
        vecs[12] = '{3'b100, 4'b1111, 1'b1, 100,  4'b0000, 3'b010, 1'b0, 1'b1, 4'b0000};
        vecs[13] = '{3'b000, 4'b0000, 1'b0, 0,    4'b0000, 3'b001, 1'b0, 1'b0, 4'b0000};
        vecs[14] = '{3'b000, 4'b0000, 1'b1, 0,    4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000};
        vecs[15] = '{3'b010, 4'b0000, 1'b0, 500,  4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011};
        vecs[16] = '{3'b001, 4'b0000, 1'b1, 600,  4'b0000, 3'b000, 1'b0, 1'b1, 4'b0011};
        vecs[17] = '{3'b000, 4'b0000, 1'b0, 100,  4'b0000, 3'b010, 1'b0, 1'b1, 4'b0000};
        vecs[18] = '{3'b000, 4'b0000, 1'b0, 0,    4'b0000, 3'b001, 1'b0, 1'b0, 4'b0000};

        drive_a(3'b000, 4'b0000, 1'b0);
        drive_b(3'b000, 4'b0000, 1'b0);
        reset_a = 1'b1;
        reset_b = 1'b1;
        step();
        check_a("reset", 0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000);
        reset_a = 1'b0;

        // Table: credit build-up, multi-item purchase, coin-funded purchase,
        // user return with greedy change, return ignoring inputs.
        for (int v = 0; v < 19; v++) begin
            drive_a(vecs[v].coin, vecs[v].sel, vecs[v].trig);
            step();
            check_a($sformatf("vec%0d", v), vecs[v].total, vecs[v].item, vecs[v].ret,
                    vecs[v].rej, vecs[v].busy, vecs[v].avail);
        end
        drive_a(3'b000, 4'b0000, 1'b0);

        // Idle timeout: RETURN after exactly 100 quiet cycles.
        drive_a(3'b010, 4'b0000, 1'b0);
        step();
        check_a("to_load", 500, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0011);
        drive_a(3'b000, 4'b0000, 1'b0);
        for (int k = 1; k <= 100; k++) begin
            step();
            check($sformatf("to_busy%0d", k), 64'(bus_a.o_busy), 64'(k == 100));
        end
        drive_a(3'b100, 4'b0000, 1'b0);
        step();
        check_a("to_pay", 0, 4'b0000, 3'b010, 1'b0, 1'b0, 4'b0000);
        drive_a(3'b000, 4'b0000, 1'b0);
        step();
        check_a("to_after", 0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000);

        // Reset during payout forfeits the credit.
        drive_a(3'b100, 4'b0000, 1'b0); step();
        drive_a(3'b010, 4'b0000, 1'b0); step();
        drive_a(3'b001, 4'b0000, 1'b0); step();
        check_a("rr_load", 1600, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111);
        drive_a(3'b000, 4'b0000, 1'b1); step();
        check_a("rr_enter", 1600, 4'b0000, 3'b000, 1'b0, 1'b1, 4'b0111);
        drive_a(3'b000, 4'b0000, 1'b0); step();
        check_a("rr_pay1", 600, 4'b0000, 3'b100, 1'b0, 1'b1, 4'b0011);
        reset_a = 1'b1;
        step();
        check_a("rr_reset", 0, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0000);
        reset_a = 1'b0;

        // Credit ceiling on dut_b (MAX_TOTAL=2000).
        reset_b = 1'b0;
        drive_b(3'b100, 4'b0000, 1'b0); step();
        check_b("cap_1000", 1000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111);
        drive_b(3'b010, 4'b0000, 1'b0); step();
        check_b("cap_1500", 1500, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111);
        drive_b(3'b100, 4'b1000, 1'b0); step();
        check_b("cap_rej", 1500, 4'b0000, 3'b000, 1'b1, 1'b0, 4'b0111);
        drive_b(3'b000, 4'b0000, 1'b0); step();
        check_b("cap_pulse_end", 1500, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b0111);
        drive_b(3'b010, 4'b0000, 1'b0); step();
        check_b("cap_exact", 2000, 4'b0000, 3'b000, 1'b0, 1'b0, 4'b1111);
        drive_b(3'b000, 4'b1000, 1'b0); step();
        check_b("cap_buy", 0, 4'b1000, 3'b000, 1'b0, 1'b0, 4'b0000);

        // Random traffic on dut_b against the reference model.
        for (int n = 0; n < N_RAND; n++) begin
            bit         r_rst;
            logic [2:0] r_coin;
            logic [3:0] r_sel;
            bit         r_trig;
            r_rst  = (n == 0) || ($urandom_range(0, 199) == 0);
            r_coin = ($urandom_range(0, 9) < 3) ? 3'($urandom_range(1, 7)) : 3'b000;
            r_sel  = ($urandom_range(0, 9) < 3) ? 4'($urandom_range(1, 15)) : 4'b0000;
            r_trig = ($urandom_range(0, 19) == 0);
            if (m_credit == 0 && !m_ret) r_sel = 4'b0000;
            model_step(r_rst, r_coin, r_sel, r_trig);
            reset_b = r_rst;
            drive_b(r_coin, r_sel, r_trig);
            step();
            check_b($sformatf("rand%0d", n), m_credit, e_item, e_coin, e_rej, m_ret,
                    affordable(m_credit));
        end
        reset_b = 1'b0;
        drive_b(3'b000, 4'b0000, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/vending_machine_core.md
Name: vending_machine_core

Overview:
- Clocked, parametrised vending-machine core: holds the running credit and a wait-timeout counter.
- Resolves item purchases in priority order and dispenses change as a greedy one-coin-per-cycle sequence.
- Replaces the fixed-width combinational next-state logic with a registered FSM.
- Sits between the coin/button front end and the item/coin actuators.

Parameters:
- NUM_COINS, 3, number of coin denominations.
- NUM_ITEMS, 4, number of items.
- TOTAL_BITS, 31, credit register width.
- COIN_VALUES, {1000,500,100}, packed NUM_COINS x 32 array of coin values, index 0 lowest. Values must be strictly ascending by index.
- ITEM_PRICES, {2000,1000,500,400}, packed NUM_ITEMS x 32 array of item prices, index 0 lowest.
- WAIT_CYCLES, 100, idle cycles before automatic change return; minimum 1.
- MAX_TOTAL, 1000000, credit ceiling.

Ports:
- clk  in  1  clock.
- reset  in  1  synchronous reset, active-high.
- i_input_coin  in  NUM_COINS  coin-inserted strobes for this cycle; any subset may be set.
- i_select_item  in  NUM_ITEMS  item-select strobes for this cycle.
- i_trigger_return  in  1  user change request.
- o_available_item  out  NUM_ITEMS  bit i = current_total >= price[i].
- o_output_item  out  NUM_ITEMS  one-cycle item-dispense pulse.
- o_return_coin  out  NUM_COINS  one-hot coin-dispense pulse, at most 1 bit per cycle.
- o_coin_rejected  out  1  one-cycle pulse: coin vector refused.
- o_busy  out  1  high in RETURN; upstream must not present coins or selections.
- o_current_total  out  TOTAL_BITS  registered credit.

Behaviour:
- Single clock domain. Reset is synchronous and active-high.
- Reset values:
  - state=IDLE, current_total=0, wait_cnt=WAIT_CYCLES.
  - o_output_item, o_return_coin and o_coin_rejected all 0.
  - o_busy=0.
- Reset mid-RETURN aborts dispensing and forfeits the remaining credit.
- Register update order within one cycle, evaluated from values registered at cycle start:
  1. Coin add. in_sum = sum of COIN_VALUES[i] over set bits. If current_total+in_sum > MAX_TOTAL, the whole vector is refused: no add, and o_coin_rejected=1 next cycle.
  2. Purchases. Walk i=0..NUM_ITEMS-1 using running credit r = current_total + accepted in_sum. If i_select_item[i] and r >= price[i], then r -= price[i] and bit i is set in o_output_item next cycle. Unaffordable selections are silently dropped.
  3. Return request, evaluated after steps 1-2.
- Arithmetic is done at TOTAL_BITS+1 internally; no wrap-around is possible given MAX_TOTAL < 2^TOTAL_BITS.
- o_available_item is combinational from the registered current_total. It is valid in the same cycle as o_current_total.
- States:
  - IDLE: current_total==0.
    - Accepted coin -> ACTIVE, wait_cnt=WAIT_CYCLES.
    - Selections are ignored.
    - i_trigger_return is a no-op.
  - ACTIVE: credit > 0.
    - Accepted coin or at least one dispensed item reloads wait_cnt=WAIT_CYCLES; otherwise wait_cnt decrements.
    - Post-purchase credit 0 -> IDLE.
    - i_trigger_return, or wait_cnt reaching 0 with no reload this cycle -> RETURN.
    - Coins and purchases in the same cycle as i_trigger_return are still applied before entering RETURN.
  - RETURN: o_busy=1.
    - Each cycle, select the largest coin j with COIN_VALUES[j] <= current_total. Pulse o_return_coin[j] next cycle and subtract its value.
    - When current_total < COIN_VALUES[0], set current_total=0 and go to IDLE. This residual is forfeited; it is unreachable when all prices and coins are multiples of COIN_VALUES[0].
    - i_input_coin, i_select_item and i_trigger_return are ignored. Coins arriving in RETURN are not credited and do not raise o_coin_rejected.
- Latency:
  - Coin to credit update: 1 cycle.
  - Select to o_output_item: 1 cycle.
  - Return of N coins: N cycles, with the first coin pulse 1 cycle after entering RETURN.
- Simultaneous coin and select in the same cycle: the coin is credited first, so the inserted coin can fund the purchase.

Decomposition:
- Shared package vending_pkg holds:
  - state enum {IDLE, ACTIVE, RETURN};
  - default NUM_COINS/NUM_ITEMS/TOTAL_BITS constants;
  - default coin and price arrays.
- Sub-module vm_change_selector: combinational greedy largest-fitting-coin finder.
  - Inputs: credit, COIN_VALUES.
  - Outputs: one-hot coin, coin value, found flag.
- All state, counters and output registers live in vending_machine_core.

Test Plan:
1. Reset, insert 500 then 100 on successive cycles -> o_current_total 500 then 600; o_available_item=0011 after the second cycle; state ACTIVE.
2. Credit 1000, select items 0 and 1 in the same cycle -> o_output_item=0011 next cycle (400+500 purchased); credit 100; wait_cnt reloaded.
3. Credit 1600, i_trigger_return -> o_return_coin sequence 100 (bit2, 1000), 010 (500), 001 (100) on consecutive cycles; credit 0; IDLE; o_busy high exactly 3 cycles.
4. Credit 500, no activity, WAIT_CYCLES=100 -> RETURN entered after 100 idle cycles; a single 500 pulse; coin inserted during RETURN is not credited.
5. MAX_TOTAL=2000, credit 1500, insert 1000 -> o_coin_rejected pulse; credit stays 1500; same-cycle selection of item 3 (2000) not dispensed.
6. Credit 100, insert 500 and select item 1 in the same cycle -> o_output_item=0010; credit 100. Assert reset mid-RETURN -> all outputs 0 and credit 0 on the next edge.
